// File: rtl/serial_nibble_receiver_if.sv
// rtl/serial_nibble_receiver_if.sv - serial line in, received nibble and status out
interface serial_nibble_receiver_if;
    logic       bit_en;
    logic       serial_in;
    logic [3:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output bit_en, serial_in,
        input  data_out, data_valid, frame_error, busy
    );

    modport slave (
        input  bit_en, serial_in,
        output data_out, data_valid, frame_error, busy
    );
endinterface

// File: rtl/serial_nibble_receiver.sv
// rtl/serial_nibble_receiver.sv - framed serial receiver: start, 4 data bits MSB first, even parity, stop
module serial_nibble_receiver (
    input  logic                      clk,
    input  logic                      rst,
    serial_nibble_receiver_if.slave   rx
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t     state_q, state_d;
    logic [1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] shreg_q, shreg_d;
    logic       par_ok_q, par_ok_d;
    logic [3:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       frame_error_q, frame_error_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 2'd0;
            shreg_q       <= 4'd0;
            par_ok_q      <= 1'b0;
            data_out_q    <= 4'd0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            par_ok_q      <= par_ok_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Strobes default low so they last exactly one clk even with bit_en held high.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        par_ok_d      = par_ok_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        if (rx.bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx.serial_in) begin
                        state_d   = DATA;
                        bit_cnt_d = 2'd0;
                    end
                end
                DATA: begin
                    shreg_d   = {shreg_q[2:0], rx.serial_in};
                    bit_cnt_d = bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ~^{shreg_q, rx.serial_in};
                    state_d  = STOP;
                end
                STOP: begin
                    if (rx.serial_in && par_ok_q) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx.data_out    = data_out_q;
    assign rx.data_valid  = data_valid_q;
    assign rx.frame_error = frame_error_q;
    assign rx.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_serial_nibble_receiver.sv
// tb/tb_serial_nibble_receiver.sv - directed-vector bench for serial_nibble_receiver
module tb_serial_nibble_receiver;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   dv_cnt;
    int   fe_cnt;
    int   busy_cnt;

    serial_nibble_receiver_if rx_if ();

    serial_nibble_receiver dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_if.data_valid)  dv_cnt   <= dv_cnt + 1;
        if (rx_if.frame_error) fe_cnt   <= fe_cnt + 1;
        if (rx_if.busy)        busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_bit(input logic b);
        rx_if.bit_en    = 1'b1;
        rx_if.serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_if.bit_en    = 1'b0;
        rx_if.serial_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [3:0] nib, input logic par, input logic stop, input int gap);
        logic [6:0] bits;
        bits = {1'b0, nib, par, stop};
        for (int i = 6; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                rx_if.bit_en    = 1'b0;
                rx_if.serial_in = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            step_bit(bits[i]);
        end
    endtask

    initial begin
        int d0, f0, b0, t1;
        n_vec = 0; n_err = 0; cyc = 0; dv_cnt = 0; fe_cnt = 0; busy_cnt = 0;
        rst = 1'b1;
        rx_if.bit_en    = 1'b0;
        rx_if.serial_in = 1'b1;
        #3;
        check("rst_data_out", 32'(rx_if.data_out), 0);
        check("rst_valid",    32'(rx_if.data_valid), 0);
        check("rst_ferr",     32'(rx_if.frame_error), 0);
        check("rst_busy",     32'(rx_if.busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // good frames 10 and 5
        d0 = dv_cnt;
        send_frame(4'd10, 1'b0, 1'b1, 0);
        check("f10_data", 32'(rx_if.data_out), 10);
        check("f10_valid", 32'(rx_if.data_valid), 1);
        check("f10_ferr", 32'(rx_if.frame_error), 0);
        check("f10_busy", 32'(rx_if.busy), 0);
        idle(1);
        check("f10_valid_drop", 32'(rx_if.data_valid), 0);
        check("f10_pulses", 32'(dv_cnt - d0), 1);
        send_frame(4'd5, 1'b0, 1'b1, 0);
        check("f5_data", 32'(rx_if.data_out), 5);
        check("f5_valid", 32'(rx_if.data_valid), 1);
        idle(1);
        check("f5_valid_drop", 32'(rx_if.data_valid), 0);

        // bad parity after good 10
        send_frame(4'd10, 1'b0, 1'b1, 0);
        idle(1);
        send_frame(4'd15, 1'b1, 1'b1, 0);
        check("par_ferr", 32'(rx_if.frame_error), 1);
        check("par_valid", 32'(rx_if.data_valid), 0);
        check("par_data", 32'(rx_if.data_out), 10);
        idle(1);
        check("par_ferr_drop", 32'(rx_if.frame_error), 0);

        // bad stop bit, then good 6
        f0 = fe_cnt;
        send_frame(4'd3, 1'b0, 1'b0, 0);
        check("stop_ferr", 32'(rx_if.frame_error), 1);
        check("stop_data", 32'(rx_if.data_out), 10);
        idle(1);
        check("stop_fe_pulses", 32'(fe_cnt - f0), 1);
        send_frame(4'd6, 1'b0, 1'b1, 0);
        check("f6_data", 32'(rx_if.data_out), 6);
        check("f6_valid", 32'(rx_if.data_valid), 1);
        idle(1);

        // bit_en every 4th cycle with noise between strobes
        d0 = dv_cnt;
        b0 = busy_cnt;
        send_frame(4'd9, 1'b0, 1'b1, 3);
        check("f9_data", 32'(rx_if.data_out), 9);
        check("f9_valid", 32'(rx_if.data_valid), 1);
        idle(1);
        check("f9_pulses", 32'(dv_cnt - d0), 1);
        check("f9_busy_cycles", 32'(busy_cnt - b0), 24);

        // reset after second data bit
        step_bit(1'b0);
        step_bit(1'b1);
        step_bit(1'b0);
        check("mid_busy_pre", 32'(rx_if.busy), 1);
        rx_if.bit_en = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_data", 32'(rx_if.data_out), 0);
        check("mid_rst_busy", 32'(rx_if.busy), 0);
        check("mid_rst_valid", 32'(rx_if.data_valid), 0);
        d0 = dv_cnt;
        f0 = fe_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        check("mid_no_valid", 32'(dv_cnt - d0), 0);
        check("mid_no_ferr", 32'(fe_cnt - f0), 0);
        send_frame(4'd12, 1'b0, 1'b1, 0);
        check("f12_data", 32'(rx_if.data_out), 12);
        check("f12_valid", 32'(rx_if.data_valid), 1);
        idle(1);

        // back-to-back 1 then 14
        send_frame(4'd1, 1'b1, 1'b1, 0);
        check("b2b1_data", 32'(rx_if.data_out), 1);
        check("b2b1_valid", 32'(rx_if.data_valid), 1);
        t1 = cyc;
        send_frame(4'd14, 1'b1, 1'b1, 0);
        check("b2b2_data", 32'(rx_if.data_out), 14);
        check("b2b2_valid", 32'(rx_if.data_valid), 1);
        check("b2b_spacing", 32'(cyc - t1), 7);

        // idle line with bit_en high produces no activity
        idle(1);
        d0 = dv_cnt;
        f0 = fe_cnt;
        b0 = busy_cnt;
        repeat (10) step_bit(1'b1);
        idle(1);
        check("idle_busy", 32'(busy_cnt - b0), 0);
        check("idle_valid", 32'(dv_cnt - d0), 0);
        check("idle_ferr", 32'(fe_cnt - f0), 0);
        check("idle_data", 32'(rx_if.data_out), 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_nibble_receiver.md
# serial_nibble_receiver

- Framed serial receiver that deserializes one 4-bit nibble per frame.
- Checks even parity and the stop bit, then presents the nibble on `data_out` with a one-cycle `data_valid` strobe.
- Sits directly upstream of the 4-bit data register: its `data_out` drives that register's `d_in`, and `data_valid` qualifies the load.
- Bit timing comes from an external `bit_en` strobe, so the block works at any bit rate that is an integer division of `clk`.

## Interface
Parameters:
- none; data width is fixed at 4 bits and the frame format is fixed.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bit_en`  in  1  bit strobe; `serial_in` is sampled only on rising edges where `bit_en` = 1.
- `serial_in`  in  1  serial line; idles high.
- `data_out`  out  4  last nibble received without error; holds its value between frames.
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated.
- `frame_error`  out  1  one-cycle pulse when a frame fails the parity or stop check.
- `busy`  out  1  high while a frame is in progress, i.e. whenever the state is not IDLE.

## Operation
- Frame format, in sampled-bit order:
  - start bit = 0
  - data bits d3, d2, d1, d0 (MSB first)
  - parity bit p, where d3^d2^d1^d0^p = 0 (even parity)
  - stop bit = 1
- State register with states IDLE, DATA, PARITY, STOP; a 2-bit counter `bit_cnt`; a 4-bit shift register `shreg`.
- Every state transition and every sample happens only on edges where `bit_en` = 1. When `bit_en` = 0, all state is held and the strobes are 0.
- IDLE:
  - `serial_in` = 0 sampled → DATA, `bit_cnt` := 0.
  - `serial_in` = 1 → stay in IDLE.
- DATA:
  - `shreg` := {`shreg`[2:0], `serial_in`}, `bit_cnt` := `bit_cnt` + 1.
  - When `bit_cnt` = 3 at the sample (4th data bit) → PARITY.
- PARITY: store p and compute `par_ok` = ^{`shreg`, p} == 0 → STOP.
- STOP, evaluated on the stop sample:
  - `serial_in` = 1 and `par_ok` = 1: `data_out` := `shreg`, `data_valid` := 1.
  - Otherwise: `frame_error` := 1 and `data_out` is left unchanged.
  - In both cases → IDLE.
- There is no error recovery beyond returning to IDLE.
  - A frame whose stop bit is 0 returns to IDLE anyway.
  - The next 0 sampled in IDLE then counts as a start bit.
- `data_valid` and `frame_error` are never high in the same cycle.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - State = IDLE, `bit_cnt` = 0, `shreg` = 0.
  - `data_out` = 4'd0, `data_valid` = 0, `frame_error` = 0, `busy` = 0.
- Reset mid-frame abandons the frame with no strobe. Reception resumes with the first start bit sampled after `rst` falls.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: `data_valid`/`frame_error` and the new `data_out` become visible after the rising edge that samples the stop bit. The strobe stays high for exactly one `clk` cycle, even if `bit_en` is held high.
- With `bit_en` tied high, a frame takes 7 cycles. Back-to-back frames are supported: a start bit may be sampled on the edge immediately after the stop-bit edge.
- `busy` rises after the start-bit sample edge and falls after the stop-bit sample edge.
- Gaps in `bit_en` of any length, including mid-frame, only stretch the frame; results are identical.

## Test plan
- Reset, then send frame 0,1,0,1,0,p=0,1 with `bit_en`=1 every cycle → after the 7th edge `data_out` = 4'd10 and `data_valid` high for one cycle. Follow with 0,0,1,0,1,p=0,1 → `data_out` = 4'd5 with one `data_valid` pulse.
- Frame for 4'd15 with p=1 (bad parity) after a good 4'd10 → `frame_error` pulses for one cycle, `data_valid` stays 0, `data_out` remains 10.
- Frame for 4'd3 (p=0) with stop bit = 0 → `frame_error` pulse. A following good frame for 4'd6 is received correctly, giving `data_out` = 6.
- `bit_en` high only every 4th cycle, frame for 4'd9 (p=0), `serial_in` toggled randomly on non-strobe cycles → `data_out` = 9, one `data_valid` pulse, `busy` high for 24 cycles.
- Assert `rst` after the 2nd data bit of a frame → all outputs 0 immediately, no strobe. A new frame for 4'd12 sent after release yields `data_out` = 12.
- Two frames, 4'd1 then 4'd14, sent back-to-back with no idle bits → two `data_valid` pulses 7 cycles apart with `data_out` = 1 then 14; `serial_in` held at 1 in IDLE produces no activity.
